// File: rtl/kf_cov_sched_if.sv
// Operand/result bus between the scheduler and the shared 2x2 covariance engine.
interface kf_cov_sched_if #(
  parameter int N = 20
);
  logic         start;
  logic [4*N-1:0] a;
  logic [4*N-1:0] p;
  logic [4*N-1:0] q;
  logic         done;
  logic [4*N-1:0] s;

  modport master (output start, a, p, q, input done, s);
  modport slave  (input start, a, p, q, output done, s);
endinterface

// File: rtl/kf_cov_sched.sv
// Round-robin scheduler sharing one S = A*P*A^T + Q engine among NCH KF channels.
// Optional job/timeout statistics counters: define KF_COV_SCHED_STAT_EN.
module kf_cov_sched #(
  parameter int N   = 20,
  parameter int NCH = 4,
  parameter int TMO = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          req,
  input  logic [NCH*4*N-1:0]      a_in,
  input  logic [NCH*4*N-1:0]      p_in,
  input  logic [NCH*4*N-1:0]      q_in,
  output logic [NCH-1:0]          gnt,
  output logic                    busy,
  kf_cov_sched_if.master          eng,
  output logic                    res_valid,
  output logic [$clog2(NCH)-1:0]  res_ch,
  output logic [4*N-1:0]          res_s,
  output logic                    err_tmo
`ifdef KF_COV_SCHED_STAT_EN
  ,
  output logic [15:0]             stat_done_cnt,
  output logic [7:0]              stat_tmo_cnt
`endif
);

  localparam int CW = $clog2(NCH);
  localparam int W  = 4*N;
  localparam logic [7:0] WD_LIM = 8'(TMO - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ptr_q;
  logic [CW-1:0] win_idx;
  logic [CW-1:0] cand;
  logic          win_found;
  logic [7:0]    wd_q;

  // First requester strictly after the last winner, wrapping modulo NCH.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = CW'((32'(ptr_q) + i) % NCH);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_tmo = 1'b0;
    case (state_q)
      S_IDLE:    if (win_found) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (eng.done) begin
          state_d = S_DELIVER;
        end else if (wd_q == WD_LIM) begin
          err_tmo = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DELIVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign eng.start = (state_q == S_ISSUE);
  assign res_valid = (state_q == S_DELIVER);

  // res_ch is loaded with the winner at capture so it is already valid
  // in the combinational err_tmo cycle as well as in DELIVER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= CW'(NCH - 1);
      gnt    <= '0;
      eng.a  <= '0;
      eng.p  <= '0;
      eng.q  <= '0;
      res_ch <= '0;
      res_s  <= '0;
      wd_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            gnt    <= NCH'(1) << win_idx;
            eng.a  <= a_in[win_idx*W +: W];
            eng.p  <= p_in[win_idx*W +: W];
            eng.q  <= q_in[win_idx*W +: W];
            ptr_q  <= win_idx;
            res_ch <= win_idx;
          end
        end
        S_ISSUE: wd_q <= '0;
        S_WAIT: begin
          wd_q <= wd_q + 8'd1;
          if (eng.done)    res_s <= eng.s;
          else if (err_tmo) gnt  <= '0;
        end
        S_DELIVER: gnt <= '0;
        default: ;
      endcase
    end
  end

`ifdef KF_COV_SCHED_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done_cnt <= '0;
      stat_tmo_cnt  <= '0;
    end else begin
      if (res_valid && (stat_done_cnt != '1)) stat_done_cnt <= stat_done_cnt + 16'd1;
      if (err_tmo && (stat_tmo_cnt != '1))    stat_tmo_cnt  <= stat_tmo_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kf_cov_sched.sv
// Scoreboard bench for kf_cov_sched with a behavioural covariance engine model.
module tb_kf_cov_sched;
  localparam int N = 20, NCH = 4, TMO = 15, W = 4*N;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   req = '0;
  logic [NCH*W-1:0] a_in = '0, p_in = '0, q_in = '0;
  logic [NCH-1:0]   gnt;
  logic             busy, res_valid, err_tmo;
  logic [1:0]       res_ch;
  logic [W-1:0]     res_s;
`ifdef KF_COV_SCHED_STAT_EN
  logic [15:0]      stat_done_cnt;
  logic [7:0]       stat_tmo_cnt;
`endif

  kf_cov_sched_if #(.N(N)) eng_if ();

  kf_cov_sched #(.N(N), .NCH(NCH), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a_in(a_in), .p_in(p_in), .q_in(q_in),
    .gnt(gnt), .busy(busy), .eng(eng_if),
    .res_valid(res_valid), .res_ch(res_ch), .res_s(res_s), .err_tmo(err_tmo)
`ifdef KF_COV_SCHED_STAT_EN
    , .stat_done_cnt(stat_done_cnt), .stat_tmo_cnt(stat_tmo_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, last_start = -1;

  typedef struct {
    bit           tmo;
    int           ch;
    logic [W-1:0] s;
    int           cyc;
  } ev_t;
  ev_t obs_q[$];
  ev_t exp_q[$];

  // Fixed-point (FRAC=10) reference for S = A*P*A^T + Q.
  function automatic logic [W-1:0] cov_s(input logic [W-1:0] a, input logic [W-1:0] p,
                                         input logic [W-1:0] q);
    longint av[4], pv[4], qv[4], m[4], s[4];
    logic [W-1:0] r;
    for (int k = 0; k < 4; k++) begin
      av[k] = longint'($signed(a[k*N +: N]));
      pv[k] = longint'($signed(p[k*N +: N]));
      qv[k] = longint'($signed(q[k*N +: N]));
    end
    m[0] = (av[0]*pv[0] + av[1]*pv[2]) >>> 10;
    m[1] = (av[0]*pv[1] + av[1]*pv[3]) >>> 10;
    m[2] = (av[2]*pv[0] + av[3]*pv[2]) >>> 10;
    m[3] = (av[2]*pv[1] + av[3]*pv[3]) >>> 10;
    s[0] = ((m[0]*av[0] + m[1]*av[1]) >>> 10) + qv[0];
    s[1] = ((m[0]*av[2] + m[1]*av[3]) >>> 10) + qv[1];
    s[2] = ((m[2]*av[0] + m[3]*av[1]) >>> 10) + qv[2];
    s[3] = ((m[2]*av[2] + m[3]*av[3]) >>> 10) + qv[3];
    for (int k = 0; k < 4; k++) r[k*N +: N] = s[k][N-1:0];
    return r;
  endfunction

  // Engine model: done eng_lat cycles after start unless hung; stray injects done.
  int           eng_lat = 8;
  bit           eng_hang = 1'b0;
  bit           stray = 1'b0;
  logic         eng_busy;
  int           eng_cnt;
  logic [W-1:0] eng_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_if.done <= 1'b0;
      eng_if.s    <= '0;
      eng_busy    <= 1'b0;
      eng_cnt     <= 0;
      eng_res     <= '0;
    end else begin
      eng_if.done <= stray;
      if (eng_if.start) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 1;
        eng_res  <= cov_s(eng_if.a, eng_if.p, eng_if.q);
      end else if (eng_busy) begin
        if (eng_cnt == eng_lat - 1) begin
          eng_busy <= 1'b0;
          if (!eng_hang) begin
            eng_if.done <= 1'b1;
            eng_if.s    <= eng_res;
          end
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    ev_t e;
    cyc++;
    #1;
    if (res_valid || err_tmo) begin
      e.tmo = err_tmo;
      e.ch  = int'(res_ch);
      e.s   = res_s;
      e.cyc = cyc;
      obs_q.push_back(e);
    end
    if (eng_if.start) last_start = cyc;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task test_reset;
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (eng_if.start !== 1'b0 || res_valid !== 1'b0 || err_tmo !== 1'b0) begin
      failures++; $display("FAIL reset_pulses got=%b%b%b want=000", eng_if.start, res_valid, err_tmo); end
    checks++; if (eng_if.a !== '0 || eng_if.p !== '0 || eng_if.q !== '0) begin
      failures++; $display("FAIL reset_operands got=%h want=0", eng_if.a); end
    checks++; if (res_s !== '0 || res_ch !== 2'd0) begin
      failures++; $display("FAIL reset_result got=%h/%0d want=0/0", res_s, res_ch); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle got=%b want=0", busy); end
  endtask

  task test_fairness;
    logic [W-1:0] fa[NCH], fp[NCH], fq[NCH];
    logic [NCH-1:0] masks[2];
    int order[2][4];
    int njobs[2];
    ev_t o, e;
    masks[0] = 4'b1111; masks[1] = 4'b1001;
    order[0] = '{0, 1, 2, 3}; order[1] = '{0, 3, 0, 0};
    njobs[0] = 4; njobs[1] = 3;
    for (int c = 0; c < NCH; c++) begin
      fa[c] = W'({$urandom(), $urandom(), $urandom()});
      fp[c] = W'({$urandom(), $urandom(), $urandom()});
      fq[c] = W'({$urandom(), $urandom(), $urandom()});
      a_in[c*W +: W] = fa[c];
      p_in[c*W +: W] = fp[c];
      q_in[c*W +: W] = fq[c];
    end
    for (int ph = 0; ph < 2; ph++) begin
      for (int j = 0; j < njobs[ph]; j++) begin
        e.tmo = 1'b0; e.ch = order[ph][j]; e.s = cov_s(fa[e.ch], fp[e.ch], fq[e.ch]); e.cyc = 0;
        exp_q.push_back(e);
      end
      req = masks[ph];
      for (int j = 0; j < njobs[ph]; j++) begin
        for (int t = 0; t < 300 && obs_q.size() == 0; t++) @(negedge clk);
        checks++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
          failures++; $display("FAIL fair_wait got=none want=result ph=%0d job=%0d", ph, j);
        end else begin
          o = obs_q.pop_front(); e = exp_q.pop_front();
          if (o.tmo !== e.tmo || o.ch !== e.ch) begin
            failures++; $display("FAIL fair_order got=ch%0d tmo%0d want=ch%0d tmo%0d", o.ch, o.tmo, e.ch, e.tmo); end
          checks++;
          if (o.s !== e.s) begin failures++; $display("FAIL fair_s got=%h want=%h", o.s, e.s); end
          if (ph == 0) req[o.ch] = 1'b0;
          if (j < njobs[ph] - 1) begin
            for (int t = 0; t < 10 && last_start <= o.cyc; t++) @(negedge clk);
            checks++;
            if (last_start !== o.cyc + 2) begin
              failures++; $display("FAIL fair_turnaround got=%0d want=%0d", last_start, o.cyc + 2); end
          end
        end
      end
      req = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task test_single;
    ev_t o, e;
    a_in[2*W +: W] = {20'h00400, 20'h00000, 20'h00000, 20'h00400};
    p_in[2*W +: W] = {20'h00800, 20'h00000, 20'h00000, 20'h00400};
    q_in[2*W +: W] = '0;
    e.tmo = 1'b0; e.ch = 2; e.s = {20'h00800, 20'h00000, 20'h00000, 20'h00400}; e.cyc = 0;
    exp_q.push_back(e);
    req = 4'b0100;
    @(posedge clk); #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b want=0100", gnt); end
    checks++; if (eng_if.start !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL single_start got=%b/%b want=1/1", eng_if.start, busy); end
    for (int t = 0; t < 300 && obs_q.size() == 0; t++) @(negedge clk);
    checks++;
    if (obs_q.size() == 0) begin
      failures++; $display("FAIL single_wait got=none want=result");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.tmo !== 1'b0 || o.ch !== 2) begin
        failures++; $display("FAIL single_ch got=ch%0d tmo%0d want=ch2 tmo0", o.ch, o.tmo); end
      checks++; if (o.s !== e.s) begin failures++; $display("FAIL single_s got=%h want=%h", o.s, e.s); end
      checks++; if (o.cyc !== last_start + 9) begin
        failures++; $display("FAIL single_latency got=%0d want=%0d", o.cyc - last_start, 9); end
      req[2] = 1'b0;
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b0 || gnt !== 4'b0000) begin
        failures++; $display("FAIL single_pulse got=%b/%b want=0/0000", res_valid, gnt); end
    end
    @(negedge clk);
  endtask

  logic [W-1:0] snap_s;

  task test_snapshot;
    logic [W-1:0] sa, sp, sq;
    ev_t o, e;
    sa = W'({$urandom(), $urandom(), $urandom()});
    sp = W'({$urandom(), $urandom(), $urandom()});
    sq = W'({$urandom(), $urandom(), $urandom()});
    a_in[1*W +: W] = sa; p_in[1*W +: W] = sp; q_in[1*W +: W] = sq;
    snap_s = cov_s(sa, sp, sq);
    e.tmo = 1'b0; e.ch = 1; e.s = snap_s; e.cyc = 0;
    exp_q.push_back(e);
    req = 4'b0010;
    @(posedge clk); #1;
    p_in[1*W +: W] = ~sp;
    checks++; if (eng_if.p !== sp) begin failures++; $display("FAIL snap_eng_p got=%h want=%h", eng_if.p, sp); end
    for (int t = 0; t < 300 && obs_q.size() == 0; t++) @(negedge clk);
    checks++;
    if (obs_q.size() == 0) begin
      failures++; $display("FAIL snap_wait got=none want=result");
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.ch !== 1 || o.s !== e.s) begin
        failures++; $display("FAIL snap_s got=ch%0d %h want=ch1 %h", o.ch, o.s, e.s); end
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task test_watchdog;
    ev_t o, e;
    eng_hang = 1'b1;
    e.tmo = 1'b1; e.ch = 0; e.s = snap_s; e.cyc = 0;
    exp_q.push_back(e);
    e.tmo = 1'b0; e.ch = 1; e.s = cov_s(a_in[1*W +: W], p_in[1*W +: W], q_in[1*W +: W]);
    exp_q.push_back(e);
    req = 4'b0011;
    for (int j = 0; j < 2; j++) begin
      for (int t = 0; t < 300 && obs_q.size() == 0; t++) @(negedge clk);
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL wdog_wait got=none want=event job=%0d", j);
      end else begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        if (o.tmo !== e.tmo || o.ch !== e.ch) begin
          failures++; $display("FAIL wdog_kind got=ch%0d tmo%0d want=ch%0d tmo%0d", o.ch, o.tmo, e.ch, e.tmo); end
        checks++;
        if (o.s !== e.s) begin failures++; $display("FAIL wdog_s got=%h want=%h", o.s, e.s); end
        req[o.ch] = 1'b0;
        if (j == 0) begin
          eng_hang = 1'b0;
          checks++; if (o.cyc !== last_start + TMO) begin
            failures++; $display("FAIL wdog_delay got=%0d want=%0d", o.cyc - last_start, TMO); end
          @(posedge clk); #1;
          checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || res_valid !== 1'b0) begin
            failures++; $display("FAIL wdog_idle got=%b/%b/%b want=0/0000/0", busy, gnt, res_valid); end
        end
      end
    end
    req = '0;
    repeat (2) @(negedge clk);
`ifdef KF_COV_SCHED_STAT_EN
    checks++; if (stat_done_cnt !== 16'd10) begin
      failures++; $display("FAIL stat_done got=%0d want=10", stat_done_cnt); end
    checks++; if (stat_tmo_cnt !== 8'd1) begin
      failures++; $display("FAIL stat_tmo got=%0d want=1", stat_tmo_cnt); end
`endif
  endtask

  task test_reset_mid;
    bit seen;
    seen = 1'b0;
    req = 4'b0100;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(posedge clk); #1;
      seen = eng_if.start;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL rstmid_start got=0 want=1");
    end else begin
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || eng_if.start !== 1'b0) begin
        failures++; $display("FAIL rstmid_ctrl got=%b/%b/%b want=0000/0/0", gnt, busy, eng_if.start); end
      checks++; if (eng_if.a !== '0 || eng_if.p !== '0 || res_s !== '0 || res_ch !== 2'd0) begin
        failures++; $display("FAIL rstmid_data got=%h/%h/%0d want=0/0/0", eng_if.a, res_s, res_ch); end
    end
    req = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (obs_q.size() !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_stray got=%0d events busy=%b want=0 events busy=0", obs_q.size(), busy); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_snapshot();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
